// File: rtl/bpsk_sym_feeder_pkg.sv
// Shared encodings for the BPSK symbol source: bit-source modes,
// antipodal sample values and PRBS-9 generator constants.
package bpsk_sym_feeder_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS = 2'b00,
        MODE_ALT  = 2'b01,
        MODE_ONES = 2'b10,
        MODE_EXT  = 2'b11
    } mode_e;

    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

    // x^9 + x^5 + 1; tap numbers are 1-based stage positions
    localparam int unsigned PRBS_TAP_A = 9;
    localparam int unsigned PRBS_TAP_B = 5;
    localparam logic [8:0]  PRBS_DEFAULT_SEED = 9'h1FF;

    function automatic logic [1:0] map_sym(input logic b);
        return b ? SYM_POS : SYM_NEG;
    endfunction

endpackage

// File: rtl/bpsk_sym_feeder_if.sv
// Sample handshake between the symbol source and the RRC FIR.
interface bpsk_sym_feeder_if;

    logic       fir_rfd;
    logic       fir_nd;
    logic [1:0] fir_din;

    modport master (
        input  fir_rfd,
        output fir_nd,
        output fir_din
    );

    modport slave (
        output fir_rfd,
        input  fir_nd,
        input  fir_din
    );

endinterface

// File: rtl/bpsk_sym_feeder_prbs9.sv
// PRBS-9 bit source: shifts once per advance strobe and reloads the
// seed instead of shifting if it ever finds the all-zero lockup state.
module prbs9_gen
    import bpsk_sym_feeder_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS_DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic prbs_bit
);

    localparam logic [8:0] LOAD = (SEED == '0) ? PRBS_DEFAULT_SEED : SEED;

    logic [8:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else if (advance) begin
            if (state == '0)
                state <= LOAD;
            else
                state <= {state[7:0], state[PRBS_TAP_A-1] ^ state[PRBS_TAP_B-1]};
        end
    end

    // Lockup state has bit 8 clear, so the emitted bit is 0 in that case.
    assign prbs_bit = state[8];

endmodule

// File: rtl/bpsk_sym_feeder.sv
// BPSK symbol source: phase-accumulator symbol tick, bit-source mux,
// antipodal mapping and rfd/nd handshake towards the RRC FIR.
module bpsk_sym_feeder
    import bpsk_sym_feeder_pkg::*;
#(
    parameter logic [31:0] PHASE_INC = 32'd257698038,
    parameter logic [8:0]  PRBS_SEED = 9'h1FF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic                      ext_bit,
    bpsk_sym_feeder_if.master         fir,
    output logic                      bit_out,
    output logic                      sym_strobe,
    output logic                      underrun,
    input  logic                      underrun_clr
);

    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;
    logic        alt;
    logic        pend;
    logic        xfer;
    logic [1:0]  din_q;
    logic        sym_bit;
    logic        prbs_bit;
    logic        prbs_adv;
    mode_e       mode_sel;

    assign acc_sum  = {1'b0, acc} + {1'b0, PHASE_INC};
    assign tick     = acc_sum[32] & enable;
    assign mode_sel = mode_e'(mode);
    assign prbs_adv = tick && (mode_sel == MODE_PRBS);

    prbs9_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (prbs_adv),
        .prbs_bit (prbs_bit)
    );

    always_comb begin
        sym_bit = 1'b0;
        case (mode_sel)
            MODE_PRBS: sym_bit = prbs_bit;
            MODE_ALT:  sym_bit = ~alt;
            MODE_ONES: sym_bit = 1'b1;
            MODE_EXT:  sym_bit = ext_bit;
        endcase
    end

    assign xfer        = pend & fir.fir_rfd;
    assign fir.fir_nd  = xfer;
    assign fir.fir_din = din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            alt        <= 1'b0;
            pend       <= 1'b0;
            din_q      <= '0;
            bit_out    <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            acc        <= enable ? acc_sum[31:0] : '0;
            sym_strobe <= tick;
            if (tick) begin
                bit_out <= sym_bit;
                din_q   <= map_sym(sym_bit);
            end
            if (tick && (mode_sel == MODE_ALT))
                alt <= ~alt;
            // A tick on a transfer edge re-arms pend with the new sample.
            if (!enable)
                pend <= 1'b0;
            else if (tick)
                pend <= 1'b1;
            else if (xfer)
                pend <= 1'b0;
            if (tick && pend && !fir.fir_rfd)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpsk_sym_feeder.sv
// Scoreboard bench for bpsk_sym_feeder: a fast-tick instance (PHASE_INC=2^31)
// for symbol/handshake checks and a default instance for symbol-rate timing.
`timescale 1ns/1ps
module tb_bpsk_sym_feeder;
    import bpsk_sym_feeder_pkg::*;

    typedef struct {
        logic       b;
        logic [1:0] din;
    } sym_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic       ext_a = 1'b0, ext_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [1:0] mode_a = 2'b00, mode_b = 2'b10;
    logic       bit_a, stb_a, und_a;
    logic       bit_b, stb_b, und_b;

    bpsk_sym_feeder_if fir_a();
    bpsk_sym_feeder_if fir_b();

    bpsk_sym_feeder #(
        .PHASE_INC (32'h8000_0000),
        .PRBS_SEED (9'h1FF)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (en_a),
        .mode         (mode_a),
        .ext_bit      (ext_a),
        .fir          (fir_a),
        .bit_out      (bit_a),
        .sym_strobe   (stb_a),
        .underrun     (und_a),
        .underrun_clr (clr_a)
    );

    bpsk_sym_feeder dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (en_b),
        .mode         (mode_b),
        .ext_bit      (ext_b),
        .fir          (fir_b),
        .bit_out      (bit_b),
        .sym_strobe   (stb_b),
        .underrun     (und_b),
        .underrun_clr (clr_b)
    );

    always #10 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    sym_t sym_q[$];
    sym_t xfer_q[$];
    logic rx_bits[$];
    logic chk_nd = 1'b0;
    logic [8:0] prbs_m = 9'h1FF;
    logic alt_m = 1'b0;

    bit   b_count_on = 1'b0;
    int   b_ticks = 0;
    int   b_last = -1;
    int   cyc_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference bit sources: only the mode being pushed advances its state.
    task automatic push_sym(input logic [1:0] m, input logic ext, input logic xfer);
        sym_t s;
        logic b;
        case (m)
            2'b00: begin
                b = prbs_m[8];
                prbs_m = {prbs_m[7:0], prbs_m[8] ^ prbs_m[4]};
            end
            2'b01: begin
                b = ~alt_m;
                alt_m = ~alt_m;
            end
            2'b10: b = 1'b1;
            default: b = ext;
        endcase
        s.b = b;
        s.din = b ? 2'b01 : 2'b11;
        sym_q.push_back(s);
        if (xfer) xfer_q.push_back(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        fir_a.fir_rfd = 1'b1; fir_b.fir_rfd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prbs_m = 9'h1FF;
        alt_m = 1'b0;
        @(negedge clk);
    endtask

    // Ticks land on every even enabled edge; an odd count lets the last sample transfer.
    task automatic run_mode(input logic [1:0] m, input int n);
        mode_a = m;
        for (int i = 0; i < n; i++) push_sym(m, 1'b0, 1'b1);
        en_a = 1'b1;
        repeat (2 * n + 1) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_symq_empty"}, sym_q.size(), 0);
        check({tag, "_xferq_empty"}, xfer_q.size(), 0);
    endtask

    always begin : mon_a
        sym_t e;
        @(negedge clk);
        #5;
        if (stb_a === 1'b1) begin
            if (sym_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: bit %0b din %0b with empty queue at %0t", bit_a, fir_a.fir_din, $time);
            end else begin
                e = sym_q.pop_front();
                check("sym_bit", bit_a, e.b);
                check("sym_din", fir_a.fir_din, e.din);
            end
            rx_bits.push_back(bit_a);
        end
        if (fir_a.fir_nd === 1'b1) begin
            if (xfer_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_transfer: din %0b with empty queue at %0t", fir_a.fir_din, $time);
            end else begin
                e = xfer_q.pop_front();
                check("xfer_din", fir_a.fir_din, e.din);
            end
        end
        if (chk_nd) check("nd_eq_strobe", fir_a.fir_nd, stb_a);
    end

    always begin : mon_b
        int gap;
        @(negedge clk);
        #5;
        cyc_b++;
        if (b_count_on && stb_b === 1'b1) begin
            b_ticks++;
            if (b_last >= 0) begin
                gap = cyc_b - b_last;
                check("tick_spacing", 32'(gap == 16 || gap == 17), 1);
            end
            b_last = cyc_b;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] v;
        int ones;
        int k;
        bit found;
        bit rep_ok;

        do_reset();
        #1;
        check("rst_bit_out", bit_a, 1'b0);
        check("rst_fir_din", fir_a.fir_din, 2'b00);
        check("rst_strobe", stb_a, 1'b0);
        check("rst_underrun", und_a, 1'b0);
        check("rst_nd", fir_a.fir_nd, 1'b0);

        // PRBS-9 stream at one symbol per two clocks
        rx_bits.delete();
        chk_nd = 1'b1;
        run_mode(MODE_PRBS, 515);
        chk_nd = 1'b0;
        check_queues("prbs");
        check("prbs_rx_count", rx_bits.size(), 515);
        if (rx_bits.size() >= 515) begin
            v = '0;
            for (int i = 0; i < 10; i++) v = {v[8:0], rx_bits[i]};
            check("prbs_first10", v, 10'b11_1111_1110);
            ones = 0;
            for (int i = 0; i < 511; i++) ones += int'(rx_bits[i]);
            check("prbs_ones_511", ones, 256);
            rep_ok = 1'b1;
            for (int i = 0; i < 4; i++) if (rx_bits[i + 511] !== rx_bits[i]) rep_ok = 1'b0;
            check("prbs_period", 32'(rep_ok), 1);
        end

        // Mode switching; PRBS and ALT state must hold across other modes
        do_reset();
        rx_bits.delete();
        run_mode(MODE_ALT, 4);
        run_mode(MODE_PRBS, 10);
        run_mode(MODE_ONES, 2);
        run_mode(MODE_ALT, 2);
        run_mode(MODE_PRBS, 3);
        mode_a = MODE_EXT;
        v = 10'b00_0000_1001;
        en_a = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            ext_a = v[i];
            push_sym(MODE_EXT, v[i], 1'b1);
            @(negedge clk);
            @(negedge clk);
        end
        ext_a = 1'b0;
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        check_queues("modes");
        check("modes_rx_count", rx_bits.size(), 25);
        if (rx_bits.size() >= 25) begin
            check("alt_first4", {rx_bits[0], rx_bits[1], rx_bits[2], rx_bits[3]}, 4'b1010);
            v = '0;
            for (int i = 4; i < 14; i++) v = {v[8:0], rx_bits[i]};
            check("prbs_after_alt", v, 10'b11_1111_1110);
            check("ones_hold", {rx_bits[14], rx_bits[15]}, 2'b11);
            check("alt_resume", {rx_bits[16], rx_bits[17]}, 2'b10);
            check("prbs_resume", {rx_bits[18], rx_bits[19], rx_bits[20]}, 3'b000);
            check("ext_bits", {rx_bits[21], rx_bits[22], rx_bits[23], rx_bits[24]}, 4'b1001);
        end

        // Underrun: FIR stalls across two ticks, then one transfer of the second sample
        do_reset();
        mode_a = MODE_ALT;
        fir_a.fir_rfd = 1'b0;
        push_sym(MODE_ALT, 1'b0, 1'b0);
        push_sym(MODE_ALT, 1'b0, 1'b1);
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("underrun_set", und_a, 1'b1);
        check("din_second_sym", fir_a.fir_din, 2'b11);
        fir_a.fir_rfd = 1'b1;
        #1;
        check("nd_after_rfd", fir_a.fir_nd, 1'b1);
        @(negedge clk);
        #1;
        check("nd_single_pulse", fir_a.fir_nd, 1'b0);
        en_a = 1'b0;
        @(negedge clk);
        check("underrun_sticky", und_a, 1'b1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        #1;
        check("underrun_cleared", und_a, 1'b0);
        fir_a.fir_rfd = 1'b0;
        push_sym(MODE_ALT, 1'b0, 1'b0);
        push_sym(MODE_ALT, 1'b0, 1'b0);
        en_a = 1'b1;
        repeat (3) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        #1;
        check("underrun_set_wins", und_a, 1'b1);
        clr_a = 1'b0;
        en_a = 1'b0;
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        #1;
        check("underrun_cleared2", und_a, 1'b0);
        check_queues("underrun");

        // One-clock rfd stall, then a tick coinciding with a transfer
        do_reset();
        mode_a = MODE_ALT;
        for (int i = 0; i < 4; i++) push_sym(MODE_ALT, 1'b0, 1'b1);
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        fir_a.fir_rfd = 1'b0;
        #1;
        check("nd_deferred", fir_a.fir_nd, 1'b0);
        @(negedge clk);
        fir_a.fir_rfd = 1'b1;
        #1;
        check("nd_resumed", fir_a.fir_nd, 1'b1);
        @(negedge clk);
        #1;
        check("nd_back_to_back", fir_a.fir_nd, 1'b1);
        check("no_underrun_coincide", und_a, 1'b0);
        repeat (5) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        check("no_underrun_stream", und_a, 1'b0);
        check_queues("b2b");

        // Asynchronous reset mid-stream drops the pending sample
        do_reset();
        mode_a = MODE_ONES;
        fir_a.fir_rfd = 1'b0;
        push_sym(MODE_ONES, 1'b0, 1'b0);
        push_sym(MODE_ONES, 1'b0, 1'b0);
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        #7;
        check("pre_reset_underrun", und_a, 1'b1);
        fir_a.fir_rfd = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_bit_out", bit_a, 1'b0);
        check("async_rst_din", fir_a.fir_din, 2'b00);
        check("async_rst_strobe", stb_a, 1'b0);
        check("async_rst_underrun", und_a, 1'b0);
        check("async_rst_nd", fir_a.fir_nd, 1'b0);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_nd", fir_a.fir_nd, 1'b0);
        check_queues("reset");

        // Default increment: symbol rate over 50000 clocks
        mode_b = MODE_ONES;
        fir_b.fir_rfd = 1'b1;
        b_ticks = 0;
        b_last = -1;
        b_count_on = 1'b1;
        en_b = 1'b1;
        repeat (50000) @(negedge clk);
        #6;
        b_count_on = 1'b0;
        en_b = 1'b0;
        check("ticks_in_50k", 32'(b_ticks >= 2999 && b_ticks <= 3001), 1);

        // Enable low for 10 clocks, then restart from phase 0
        @(negedge clk);
        en_b = 1'b1;
        repeat (37) @(negedge clk);
        en_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("disabled_nd", fir_b.fir_nd, 1'b0);
            check("disabled_strobe", stb_b, 1'b0);
        end
        en_b = 1'b1;
        k = 0;
        found = 1'b0;
        while (k < 40 && !found) begin
            @(negedge clk);
            k++;
            #1;
            if (stb_b === 1'b1) found = 1'b1;
        end
        check("reenable_first_tick", k, 17);
        en_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
